bpa_align_seq: RTL and testbench
================================

// Module: bpa_align_seq
// PURPOSE
//  Field sequencer for the BPA nibble aligner: walks a programmable field-width list, waits for
//  the aligner to present enough valid nibbles, pulses the one-hot decAlignShift* for that width,
//  and captures the field into a registered valid/ready output toward the BPA parser.
//  Sits between the aligner's out*Valid/alignDecData outputs and the parser's field consumer.
// PARAMETERS
//  NUM_FIELDS  8   entries in the field-width program table (max fields per frame)
//  IDX_W       3   log2(NUM_FIELDS); width of table address and field index
// PORTS
//  clk          in   1      single clock; all logic posedge
//  reset        in   1      synchronous, active-high reset
//  cfg_we       in   1      program-table write strobe (accepted only when busy==0)
//  cfg_addr     in   IDX_W  table entry to write
//  cfg_width    in   3      field width in nibbles: 1..6 = 4..24 bits; 0 or 7 = END marker
//  frm_start    in   1      pulse: begin sequencing from entry 0 (ignored when busy==1)
//  frm_abort    in   1      pulse: abandon current frame, return to IDLE
//  busy         out  1      high from accepted start until DONE/abort exit
//  frm_done     out  1      one-cycle pulse when the last field of a frame is accepted downstream
//  cfg_err      out  1      one-cycle pulse when cfg_we arrives while busy (write dropped)
//  out4Valid..out24Valid in 1 each  aligner thermometer valids (4,8,12,16,20,24 bits)
//  alignDecData in   32     aligner data, MSB-justified
//  decAlignShift4..decAlignShift24 out 1 each  one-hot shift commands to aligner
//  fld_data     out  24     captured field, right-justified, upper bits zero
//  fld_idx      out  IDX_W  table index of fld_data
//  fld_last     out  1      fld_data is the final field of the frame
//  fld_vld      out  1      field output valid
//  fld_rdy      in   1      downstream ready; transfer when fld_vld & fld_rdy
// BEHAVIOUR
//  Reset: state IDLE, table all 0 (END), every output 0.
//  States: IDLE -> RUN (frm_start & !busy) -> DRAIN (last field captured) -> IDLE (drained).
//   RUN: cur = table[idx]. If cur is END at idx 0 -> frm_done pulse, IDLE (zero-field frame).
//   Shift issue (combinational, RUN only): need = out{4*cur}Valid; slot free = !fld_vld | fld_rdy.
//    need & slot free & !frm_abort -> assert decAlignShift{4*cur} (exactly one, same cycle);
//    at that edge capture alignDecData[31 -: 4*cur] into fld_data, fld_idx=idx, fld_vld=1.
//   Field latency: one cycle from shift pulse to fld_vld. Back-to-back fields every cycle when
//    aligner valid and fld_rdy held high.
//   fld_last=1 when idx==NUM_FIELDS-1 or table[idx+1] is END; then go DRAIN, else idx++.
//   DRAIN: no shifts; when last field transfers -> frm_done pulse, busy=0, IDLE.
//  decAlignShift* all 0 outside RUN; never more than one high (zero-one-hot invariant).
//  fld_vld held, fld_data stable until transfer (no drop/change while !fld_rdy), except abort.
//  frm_abort (any state): next cycle IDLE, fld_vld=0, busy=0, no frm_done; no shift that cycle.
//  frm_start & frm_abort same cycle: abort wins, stays IDLE. Start while busy: ignored.
//  cfg_we while idle: table[cfg_addr]<=cfg_width next edge; visible to a start on following cycle.
//  Reset mid-frame: immediate return to reset state; aligner nibbles left unconsumed.
// STRUCTURE
//  Shared package bpa_align_pkg: width codes (W_END, W4..W24), state enum, helper width->mask fn.
//  One sub-module: bpa_align_prog_tbl (NUM_FIELDS x 3-bit reg file, sync write, async read).
//  Top holds FSM, index counter, shift decode and output register slice.
// TESTING
//  1 Program {2,6,1,END}; start; aligner valids all high, fld_rdy=1 -> shifts 8,24,4 on 3
//    consecutive cycles, fields idx0..2, fld_last on idx2, frm_done 1 cycle after idx2 transfer.
//  2 Same program, fld_rdy low 5 cycles after first field -> no further shift, fld_data/idx held,
//    resumes next cycle after fld_rdy rises.
//  3 Entry0=6, only out4..out16 valid for 4 cycles -> no shift; out24Valid rises -> shift24 same
//    cycle, fld_data = alignDecData[31:8].
//  4 Entry0=END, start -> frm_done next cycle, no fld_vld, no shift, busy low again.
//  5 Abort mid-frame with fld_vld=1 & fld_rdy=0 -> IDLE next cycle, fld_vld=0, no frm_done;
//    new start restarts at idx0.
//  6 cfg_we while busy -> cfg_err pulse, table unchanged (verify by re-run of test 1).

Source files
------------

// File: rtl/bpa_align_pkg.sv
// Width codes, sequencer states and width decode shared by the BPA aligner field sequencer.
package bpa_align_pkg;
  localparam logic [2:0] W_END  = 3'd0;
  localparam logic [2:0] W4     = 3'd1;
  localparam logic [2:0] W8     = 3'd2;
  localparam logic [2:0] W12    = 3'd3;
  localparam logic [2:0] W16    = 3'd4;
  localparam logic [2:0] W20    = 3'd5;
  localparam logic [2:0] W24    = 3'd6;
  localparam logic [2:0] W_END7 = 3'd7;
  localparam int SHIFT_N = 6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  function automatic logic is_end(input logic [2:0] w);
    return (w == W_END) || (w == W_END7);
  endfunction

  // One-hot select over the 4..24-bit valid/shift lines; all-zero for an END code.
  function automatic logic [SHIFT_N-1:0] width_mask(input logic [2:0] w);
    logic [SHIFT_N-1:0] m;
    m = '0;
    if (!is_end(w)) m[w - W4] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/bpa_align_prog_tbl.sv
// Field-width program table: sync write, two async read ports (current and next entry).
module bpa_align_prog_tbl
  import bpa_align_pkg::*;
#(
  parameter int NUM_FIELDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [2:0]       wdata,
  input  logic [IDX_W-1:0] raddr_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [2:0]       rdata_a,
  output logic [2:0]       rdata_b
);
  logic [NUM_FIELDS-1:0][2:0] tbl;

  always_ff @(posedge clk) begin
    if (reset) tbl <= {NUM_FIELDS{W_END}};
    else if (we) tbl[waddr] <= wdata;
  end

  assign rdata_a = tbl[raddr_a];
  assign rdata_b = tbl[raddr_b];
endmodule

// File: rtl/bpa_align_seq.sv
// Field sequencer: walks the width program, issues one-hot aligner shifts and registers
// each captured field into a valid/ready slot toward the parser.
module bpa_align_seq
  import bpa_align_pkg::*;
#(
  parameter int NUM_FIELDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [2:0]       cfg_width,
  input  logic             frm_start,
  input  logic             frm_abort,
  output logic             busy,
  output logic             frm_done,
  output logic             cfg_err,
  input  logic             out4Valid,
  input  logic             out8Valid,
  input  logic             out12Valid,
  input  logic             out16Valid,
  input  logic             out20Valid,
  input  logic             out24Valid,
  input  logic [31:0]      alignDecData,
  output logic             decAlignShift4,
  output logic             decAlignShift8,
  output logic             decAlignShift12,
  output logic             decAlignShift16,
  output logic             decAlignShift20,
  output logic             decAlignShift24,
  output logic [23:0]      fld_data,
  output logic [IDX_W-1:0] fld_idx,
  output logic             fld_last,
  output logic             fld_vld,
  input  logic             fld_rdy
);
  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [2:0]         cur_w;
  logic [2:0]         nxt_w;
  logic [SHIFT_N-1:0] valid_vec;
  logic [SHIFT_N-1:0] cur_mask;
  logic [SHIFT_N-1:0] shift_vec;
  logic               slot_free;
  logic               shift_go;
  logic               last_fld;
  logic [5:0]         shamt;
  logic [23:0]        fld_cap;

  assign busy    = (state != S_IDLE);
  assign idx_nxt = idx + 1'b1;

  // The table is frozen while a frame runs, so writes only land when idle.
  bpa_align_prog_tbl #(.NUM_FIELDS(NUM_FIELDS), .IDX_W(IDX_W)) u_tbl (
    .clk     (clk),
    .reset   (reset),
    .we      (cfg_we & ~busy),
    .waddr   (cfg_addr),
    .wdata   (cfg_width),
    .raddr_a (idx),
    .raddr_b (idx_nxt),
    .rdata_a (cur_w),
    .rdata_b (nxt_w)
  );

  assign valid_vec = {out24Valid, out20Valid, out16Valid, out12Valid, out8Valid, out4Valid};
  assign cur_mask  = width_mask(cur_w);
  assign slot_free = ~fld_vld | fld_rdy;
  assign shift_go  = (state == S_RUN) & (|(valid_vec & cur_mask)) & slot_free & ~frm_abort;
  assign shift_vec = shift_go ? cur_mask : '0;

  assign {decAlignShift24, decAlignShift20, decAlignShift16,
          decAlignShift12, decAlignShift8, decAlignShift4} = shift_vec;

  assign last_fld = (idx == IDX_W'(NUM_FIELDS - 1)) | is_end(nxt_w);

  // Right-justify the top 4*cur_w bits of the MSB-justified aligner word.
  assign shamt   = 6'd32 - {1'b0, cur_w, 2'b00};
  assign fld_cap = 24'(alignDecData >> shamt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      fld_vld  <= 1'b0;
      fld_data <= '0;
      fld_idx  <= '0;
      fld_last <= 1'b0;
      frm_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      frm_done <= 1'b0;
      cfg_err  <= cfg_we & busy;
      if (fld_vld & fld_rdy) fld_vld <= 1'b0;
      if (frm_abort) begin
        state    <= S_IDLE;
        fld_vld  <= 1'b0;
        fld_last <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (frm_start) begin
              state <= S_RUN;
              idx   <= '0;
            end
          end
          S_RUN: begin
            if (is_end(cur_w)) begin
              frm_done <= 1'b1;
              state    <= S_IDLE;
            end else if (shift_go) begin
              fld_data <= fld_cap;
              fld_idx  <= idx;
              fld_last <= last_fld;
              fld_vld  <= 1'b1;
              if (last_fld) state <= S_DRAIN;
              else          idx   <= idx_nxt;
            end
          end
          S_DRAIN: begin
            if (fld_vld & fld_rdy) begin
              frm_done <= 1'b1;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bpa_align_seq.sv
// Scoreboard bench: a nibble-stream aligner model feeds the sequencer; expected fields are
// sliced from the stream at frame setup and compared whenever a field transfers.
module tb_bpa_align_seq;
  localparam int NF = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [2:0]    cfg_width = '0;
  logic          frm_start = 1'b0;
  logic          frm_abort = 1'b0;
  logic          busy, frm_done, cfg_err;
  logic          out4Valid = 1'b0, out8Valid = 1'b0, out12Valid = 1'b0;
  logic          out16Valid = 1'b0, out20Valid = 1'b0, out24Valid = 1'b0;
  logic [31:0]   alignDecData = '0;
  logic          decAlignShift4, decAlignShift8, decAlignShift12;
  logic          decAlignShift16, decAlignShift20, decAlignShift24;
  logic [23:0]   fld_data;
  logic [IW-1:0] fld_idx;
  logic          fld_last, fld_vld;
  logic          fld_rdy = 1'b0;

  bpa_align_seq #(.NUM_FIELDS(NF), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_width(cfg_width),
    .frm_start(frm_start), .frm_abort(frm_abort), .busy(busy), .frm_done(frm_done),
    .cfg_err(cfg_err), .out4Valid(out4Valid), .out8Valid(out8Valid), .out12Valid(out12Valid),
    .out16Valid(out16Valid), .out20Valid(out20Valid), .out24Valid(out24Valid),
    .alignDecData(alignDecData), .decAlignShift4(decAlignShift4),
    .decAlignShift8(decAlignShift8), .decAlignShift12(decAlignShift12),
    .decAlignShift16(decAlignShift16), .decAlignShift20(decAlignShift20),
    .decAlignShift24(decAlignShift24), .fld_data(fld_data), .fld_idx(fld_idx),
    .fld_last(fld_last), .fld_vld(fld_vld), .fld_rdy(fld_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    int          idx;
    bit          last;
  } fld_t;

  fld_t       exp_q[$];
  bit [3:0]   pend_q[$];
  bit [3:0]   al_q[$];
  int         iss_q[$];
  logic [2:0] tbl_m[NF];
  logic [2:0] prog[NF];
  bit         vld_m = 1'b0;
  bit         in_frame = 1'b0;
  bit         feed_rand = 1'b0;
  bit         rdy_rand = 1'b0;
  bit         rdy_fix = 1'b1;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] wmask(input int w);
    return (w >= 1 && w <= 6) ? 6'(1 << (w - 1)) : 6'd0;
  endfunction

  // Aligner model + monitor: checks at negedge, consumes at posedge, drives at posedge+1.
  initial begin : mon
    logic [5:0]  sh, esh;
    fld_t        f;
    logic [23:0] p_data;
    logic [IW-1:0] p_idx;
    bit          p_hold;
    int          n;
    p_hold = 1'b0;
    forever begin
      @(negedge clk);
      sh  = {decAlignShift24, decAlignShift20, decAlignShift16,
             decAlignShift12, decAlignShift8, decAlignShift4};
      esh = '0;
      if (!reset) begin
        if (iss_q.size() > 0 && al_q.size() >= iss_q[0] && (!vld_m || fld_rdy) && !frm_abort)
          esh = wmask(iss_q[0]);
        chk("shift", 32'(sh), 32'(esh));
        chk("fld_vld", 32'(fld_vld), 32'(vld_m));
        if (p_hold && fld_vld) begin
          chk("hold_data", 32'(fld_data), 32'(p_data));
          chk("hold_idx", 32'(fld_idx), 32'(p_idx));
        end
        if (fld_vld && fld_rdy) begin
          if (exp_q.size() == 0) chk("unexpected_field", 32'(fld_idx) + 32'd1, 32'd0);
          else begin
            f = exp_q.pop_front();
            chk("fld_data", 32'(fld_data), 32'(f.data));
            chk("fld_idx", 32'(fld_idx), 32'(f.idx));
            chk("fld_last", 32'(fld_last), 32'(f.last));
          end
        end
        if (frm_done) done_cnt++;
        if (cfg_err) err_cnt++;
      end
      p_hold = fld_vld && !fld_rdy && !frm_abort && !reset;
      p_data = fld_data;
      p_idx  = fld_idx;
      @(posedge clk);
      if (reset || frm_abort) begin
        vld_m = 1'b0;
        iss_q.delete();
        exp_q.delete();
      end else if (esh != 0) begin
        n = iss_q.pop_front();
        repeat (n) void'(al_q.pop_front());
        vld_m = 1'b1;
      end else if (vld_m && fld_rdy) begin
        vld_m = 1'b0;
      end
      #1;
      n = feed_rand ? $urandom_range(0, 2) : pend_q.size();
      while (n > 0 && pend_q.size() > 0) begin
        al_q.push_back(pend_q.pop_front());
        n--;
      end
      fld_rdy      = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
      out4Valid    = al_q.size() >= 1;
      out8Valid    = al_q.size() >= 2;
      out12Valid   = al_q.size() >= 3;
      out16Valid   = al_q.size() >= 4;
      out20Valid   = al_q.size() >= 5;
      out24Valid   = al_q.size() >= 6;
      alignDecData = '0;
      for (int i = 0; i < 8; i++)
        if (i < al_q.size()) alignDecData[31 - 4*i -: 4] = al_q[i];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_tbl(input int a, input logic [2:0] w);
    cfg_we    = 1'b1;
    cfg_addr  = a[IW-1:0];
    cfg_width = w;
    cyc();
    cfg_we = 1'b0;
    if (!in_frame) tbl_m[a] = w;
  endtask

  task automatic load_prog();
    for (int i = 0; i < NF; i++) write_tbl(i, prog[i]);
  endtask

  task automatic start_frame();
    int nf, total, pos;
    logic [23:0] d;
    nf = 0;
    while (nf < NF && tbl_m[nf] >= 3'd1 && tbl_m[nf] <= 3'd6) nf++;
    al_q.delete();
    pend_q.delete();
    exp_q.delete();
    total = 0;
    for (int k = 0; k < nf; k++) total += int'(tbl_m[k]);
    total += $urandom_range(0, 3);
    for (int i = 0; i < total; i++) pend_q.push_back(4'($urandom));
    pos = 0;
    for (int k = 0; k < nf; k++) begin
      d = '0;
      for (int j = 0; j < int'(tbl_m[k]); j++) begin
        d = {d[19:0], pend_q[pos]};
        pos++;
      end
      exp_q.push_back('{d, k, (k == nf - 1)});
    end
    frm_start = 1'b1;
    cyc();
    frm_start = 1'b0;
    for (int k = 0; k < nf; k++) iss_q.push_back(int'(tbl_m[k]));
    in_frame = 1'b1;
  endtask

  task automatic wait_done(input int d0, output int n);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      cyc();
      n++;
    end
    chk("frame_timeout", 32'(done_cnt == d0), 32'd0);
    cyc();
    cyc();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("fields_left", 32'(exp_q.size()), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    in_frame = 1'b0;
  endtask

  task automatic set_prog(input logic [2:0] a0, a1, a2, a3);
    prog = '{a0, a1, a2, a3, 3'd0, 3'd0, 3'd0, 3'd0};
  endtask

  initial begin
    int d0, n, e0;
    for (int i = 0; i < NF; i++) tbl_m[i] = 3'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frm_done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_fld", {fld_vld, fld_last, fld_idx, fld_data}, 0);
    cyc();

    // Fresh table is all END: start gives a zero-field frame.
    d0 = done_cnt;
    start_frame();
    wait_done(d0, n);
    chk("zero_frame_latency", n, 2);

    // {2,6,1,END}, everything available, ready high: back-to-back fields.
    set_prog(3'd2, 3'd6, 3'd1, 3'd0);
    e0 = err_cnt;
    load_prog();
    cyc();
    chk("cfg_err_idle", err_cnt - e0, 0);
    d0 = done_cnt;
    start_frame();
    wait_done(d0, n);
    chk("b2b_done_latency", n, 5);

    // Same program, ready dropped for 5 cycles once the first field is up.
    d0 = done_cnt;
    start_frame();
    rdy_fix = 1'b0;
    repeat (5) cyc();
    rdy_fix = 1'b1;
    wait_done(d0, n);

    // Single 24-bit field with slowly arriving nibbles.
    set_prog(3'd6, 3'd7, 3'd0, 3'd0);
    load_prog();
    feed_rand = 1'b1;
    d0 = done_cnt;
    start_frame();
    wait_done(d0, n);
    feed_rand = 1'b0;

    // Abort with a field stuck on a low ready; then restart from idx 0.
    set_prog(3'd2, 3'd6, 3'd1, 3'd0);
    load_prog();
    rdy_fix = 1'b0;
    d0 = done_cnt;
    start_frame();
    repeat (3) cyc();
    frm_abort = 1'b1;
    cyc();
    frm_abort = 1'b0;
    in_frame = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    repeat (3) cyc();
    chk("abort_no_done", done_cnt - d0, 0);
    rdy_fix = 1'b1;
    d0 = done_cnt;
    start_frame();
    wait_done(d0, n);

    // Write while busy is dropped and flagged; a re-run proves the table is intact.
    rdy_fix = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame();
    write_tbl(1, 3'd3);
    cyc();
    chk("cfg_err_busy", err_cnt - e0, 1);
    rdy_fix = 1'b1;
    wait_done(d0, n);
    d0 = done_cnt;
    start_frame();
    wait_done(d0, n);

    // Random programs, feed and ready.
    feed_rand = 1'b1;
    rdy_rand  = 1'b1;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, NF);
      for (int i = 0; i < NF; i++)
        prog[i] = (i < n) ? 3'($urandom_range(1, 6)) : ($urandom_range(0, 1) ? 3'd7 : 3'd0);
      load_prog();
      d0 = done_cnt;
      start_frame();
      wait_done(d0, n);
    end

    // Reset mid-frame returns everything to the reset state.
    set_prog(3'd6, 3'd6, 3'd6, 3'd6);
    load_prog();
    start_frame();
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    in_frame = 1'b0;
    for (int i = 0; i < NF; i++) tbl_m[i] = 3'd0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_fld", {fld_vld, fld_last, fld_idx, fld_data}, 0);
    cyc();
    d0 = done_cnt;
    start_frame();
    wait_done(d0, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
